// File: rtl/sdramtx.sv
// sdramtx: capture side of the SDRAM signal recorder.
// Packs each sample set into a 4-word frame, buffers it in a 1024x32 dual-clock
// FIFO (dqfifo) and drains it to the SDRAM controller in fixed BURST_LEN bursts.
// Optional build macro SDRAMTX_FRAMECHK_EN: slot 0 carries a frame sequence
// number and slot 2 carries TRI^ST so the receiver can check frame integrity.

// Dual-clock FIFO with show-ahead read port and Gray-coded pointer crossing.
module dqfifo #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          aclr,
  input  logic          wrclk,
  input  logic          wrreq,
  input  logic [DW-1:0] data,
  output logic [AW:0]   wrusedw,
  input  logic          rdclk,
  input  logic          rdreq,
  output logic [DW-1:0] q,
  output logic          rdempty
);

  function automatic logic [AW:0] b2g(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW:0] g2b(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [DW-1:0] mem_q [2**AW];
  logic [AW:0]   wbin_q, wgray_q, rbin_q, rgray_q;
  logic [AW:0]   rg_s1_q, rg_s2_q, wg_s1_q, wg_s2_q;
  logic [AW:0]   wbin_d, rbin_d;
  logic          wrfull, wr_en, rd_en;

  // Write-side count is pessimistic: the read pointer arrives late, never early.
  assign wrusedw = wbin_q - g2b(rg_s2_q);
  assign wrfull  = wrusedw[AW];
  assign wr_en   = wrreq & ~wrfull;
  assign wbin_d  = wbin_q + 1'b1;

  assign rdempty = (rgray_q == wg_s2_q);
  assign rd_en   = rdreq & ~rdempty;
  assign rbin_d  = rbin_q + 1'b1;
  assign q       = mem_q[rbin_q[AW-1:0]];

  // Write pointer and read-pointer synchroniser in the write domain.
  always_ff @(posedge wrclk or posedge aclr) begin
    if (aclr) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      rg_s1_q <= '0;
      rg_s2_q <= '0;
    end else begin
      if (wr_en) begin
        wbin_q  <= wbin_d;
        wgray_q <= b2g(wbin_d);
      end
      rg_s1_q <= rgray_q;
      rg_s2_q <= rg_s1_q;
    end
  end

  // Storage array; contents are don't-care until the pointers cover them.
  always_ff @(posedge wrclk) begin
    if (wr_en) mem_q[wbin_q[AW-1:0]] <= data;
  end

  // Read pointer and write-pointer synchroniser in the read domain.
  always_ff @(posedge rdclk or posedge aclr) begin
    if (aclr) begin
      rbin_q  <= '0;
      rgray_q <= '0;
      wg_s1_q <= '0;
      wg_s2_q <= '0;
    end else begin
      if (rd_en) begin
        rbin_q  <= rbin_d;
        rgray_q <= b2g(rbin_d);
      end
      wg_s1_q <= wgray_q;
      wg_s2_q <= wg_s1_q;
    end
  end

endmodule

module sdramtx #(
  parameter int BURST_LEN        = 256,
  parameter int FIFO_ALMOST_FULL = 1020
) (
  input  logic        clk,
  input  logic        capclk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] PARDIN0,
  input  logic [15:0] PARDIN1,
  input  logic        wrbstack,
  output logic        wrbstrdy,
  output logic [31:0] DATAOUT,
  output logic        dqval,
  output logic        bstdone,
  output logic        ovf,
  output logic        unf
);

  localparam int          AW        = 10;
  localparam int          CW        = $clog2(BURST_LEN);
  localparam logic [AW:0] ADMIT_MAX = (AW+1)'(FIFO_ALMOST_FULL - 4);
  localparam logic [AW:0] LVL_MIN   = (AW+1)'(BURST_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, RD, DONE} bst_state_t;

  // ---------------- capture domain (capclk) ----------------
  logic [1:0]  slot_q, slot_d;
  logic [15:0] tri_q, tri_d, st_q, st_d;
  logic        ovf_q, ovf_d;
  logic        lvl_ok_q;
  logic        frame_start, frame_drop, wrreq;
  logic [15:0] up;
  logic [31:0] wdata;
  logic [AW:0] wrusedw;
`ifdef SDRAMTX_FRAMECHK_EN
  logic [15:0] seq_q, seq_d;
`endif

  // Whole-frame admission at slot 0, then slots 1..3 follow unconditionally.
  always_comb begin
    frame_start = 1'b0;
    frame_drop  = 1'b0;
    slot_d      = slot_q;
    tri_d       = tri_q;
    st_d        = st_q;
    ovf_d       = ovf_q;
    up          = 16'h0000;
    if (slot_q == 2'd0 && enable) begin
      if (wrusedw <= ADMIT_MAX) begin
        frame_start = 1'b1;
        tri_d       = PARDIN0[31:16];
        st_d        = PARDIN1;
      end else begin
        frame_drop = 1'b1;
        ovf_d      = 1'b1;
      end
    end
    wrreq = frame_start | (slot_q != 2'd0);
    if (wrreq) slot_d = slot_q + 2'd1;
    case (slot_q)
`ifdef SDRAMTX_FRAMECHK_EN
      2'd0:    up = seq_q;
      2'd1:    up = tri_q;
      2'd2:    up = tri_q ^ st_q;
`else
      2'd0:    up = 16'h0000;
      2'd1:    up = tri_q;
      2'd2:    up = 16'h0000;
`endif
      default: up = st_q;
    endcase
  end

  assign wdata = {up, PARDIN0[15:0]};

`ifdef SDRAMTX_FRAMECHK_EN
  // Dropped frames still consume a number so gaps are visible downstream.
  always_comb begin
    seq_d = seq_q;
    if (frame_start | frame_drop) seq_d = seq_q + 16'd1;
  end

  // Frame sequence counter.
  always_ff @(posedge capclk or posedge reset) begin
    if (reset) seq_q <= '0;
    else       seq_q <= seq_d;
  end
`endif

  // Capture state: slot counter, latched tri-state data, overflow, level flag.
  always_ff @(posedge capclk or posedge reset) begin
    if (reset) begin
      slot_q   <= '0;
      tri_q    <= '0;
      st_q     <= '0;
      ovf_q    <= 1'b0;
      lvl_ok_q <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      tri_q    <= tri_d;
      st_q     <= st_d;
      ovf_q    <= ovf_d;
      lvl_ok_q <= (wrusedw >= LVL_MIN);
    end
  end

  // ---------------- SDRAM domain (clk) ----------------
  bst_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_s1_q, lvl_s2_q;
  logic          rd_slot, rdreq, rdempty, done;
  logic [31:0]   q;
  logic [31:0]   dout_q, dout_d;
  logic          dqval_q, unf_q, unf_d;
  logic [1:0]    done_pipe_q;

  dqfifo #(.DW(32), .AW(AW)) u_fifo (
    .aclr    (reset),
    .wrclk   (capclk),
    .wrreq   (wrreq),
    .data    (wdata),
    .wrusedw (wrusedw),
    .rdclk   (clk),
    .rdreq   (rdreq),
    .q       (q),
    .rdempty (rdempty)
  );

  // Burst FSM: one read slot per clk for BURST_LEN clks, then a done slot.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_slot  = 1'b0;
    done     = 1'b0;
    wrbstrdy = 1'b0;
    case (state_q)
      IDLE: begin
        wrbstrdy = lvl_s2_q;
        if (wrbstack && lvl_s2_q) state_d = RD;
      end
      RD: begin
        rd_slot = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // An empty FIFO mid-burst still burns the slot so burst length stays fixed.
  always_comb begin
    rdreq  = rd_slot & ~rdempty;
    unf_d  = unf_q | (rd_slot & rdempty);
    dout_d = dout_q;
    if (rd_slot) dout_d = rdempty ? 32'h0 : q;
  end

  // FSM state, counter, level synchroniser, output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lvl_s1_q    <= 1'b0;
      lvl_s2_q    <= 1'b0;
      dout_q      <= '0;
      dqval_q     <= 1'b0;
      unf_q       <= 1'b0;
      done_pipe_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lvl_s1_q    <= lvl_ok_q;
      lvl_s2_q    <= lvl_s1_q;
      dout_q      <= dout_d;
      dqval_q     <= rd_slot;
      unf_q       <= unf_d;
      done_pipe_q <= {done_pipe_q[0], done};
    end
  end

  assign DATAOUT = dout_q;
  assign dqval   = dqval_q;
  assign bstdone = done_pipe_q[1];
  assign ovf     = ovf_q;
  assign unf     = unf_q;

endmodule

// File: tb/tb_sdramtx.sv
// Directed bench for sdramtx: reset, partial-enable frames, burst timing and
// data, overflow fill and drain, reset mid-burst, post-reset refill.
module tb_sdramtx;

  localparam int BL = 256;
`ifdef SDRAMTX_FRAMECHK_EN
  localparam bit FRAMECHK = 1'b1;
`else
  localparam bit FRAMECHK = 1'b0;
`endif

  logic        clk, capclk, reset, enable, wrbstack;
  logic [31:0] PARDIN0;
  logic [15:0] PARDIN1;
  logic        wrbstrdy, dqval, bstdone, ovf, unf;
  logic [31:0] DATAOUT;

  int checks = 0;
  int errors = 0;

  // capture stimulus state
  int          cnt = 0;
  int          en_cycles = 0;   // >0: hold enable that many capclks, -1: forever
  logic [15:0] tri_v = 16'hA5A5;
  logic [15:0] st_v  = 16'h5A5A;
  int          start_log[$];

  // expected-data description: low half is b0+k below split, b1+(k-split) above
  int          split, b0, b1;
  logic [15:0] exp_tri, exp_st;

  sdramtx #(.BURST_LEN(BL), .FIFO_ALMOST_FULL(1020)) dut (
    .clk      (clk),
    .capclk   (capclk),
    .reset    (reset),
    .enable   (enable),
    .PARDIN0  (PARDIN0),
    .PARDIN1  (PARDIN1),
    .wrbstack (wrbstack),
    .wrbstrdy (wrbstrdy),
    .DATAOUT  (DATAOUT),
    .dqval    (dqval),
    .bstdone  (bstdone),
    .ovf      (ovf),
    .unf      (unf)
  );

  // capclk edges at multiples of 3, clk edges at 1 mod 3: never coincident
  initial begin
    capclk = 1'b0;
    forever #3 capclk = ~capclk;
  end

  initial begin
    clk = 1'b0;
    #1;
    forever #6 clk = ~clk;
  end

  // capture driver: low half of PARDIN0 is a free-running counter
  initial begin
    enable  = 1'b0;
    PARDIN0 = '0;
    PARDIN1 = '0;
    forever begin
      @(negedge capclk);
      cnt     = cnt + 1;
      PARDIN0 = {tri_v, 16'(cnt)};
      PARDIN1 = st_v;
      if (en_cycles != 0) begin
        if (!enable) start_log.push_back(cnt);
        enable = 1'b1;
        if (en_cycles > 0) en_cycles = en_cycles - 1;
      end else begin
        enable = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int k);
    logic [15:0] lo, up;
    int f;
    lo = (k < split) ? 16'(b0 + k) : 16'(b1 + (k - split));
    f  = k / 4;
    case (k % 4)
      0:       up = FRAMECHK ? 16'(f) : 16'h0000;
      1:       up = exp_tri;
      2:       up = FRAMECHK ? (exp_tri ^ exp_st) : 16'h0000;
      default: up = exp_st;
    endcase
    return {up, lo};
  endfunction

  // Waits for wrbstrdy, acks, checks the whole burst. abort_k>=0 asserts
  // reset right after word abort_k is seen and checks the cleared outputs.
  task automatic run_burst(input int k0, input int abort_k);
    bit got = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (wrbstrdy === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("rdy_wait", {31'b0, got}, 32'd1);
    if (!got) return;
    wrbstack = 1'b1;
    @(negedge clk);
    wrbstack = 1'b0;
    chk("dqval_n1", {31'b0, dqval}, 32'd0);
    chk("rdy_n1", {31'b0, wrbstrdy}, 32'd0);
    for (int k = 0; k < BL; k++) begin
      @(negedge clk);
      chk("dqval_burst", {31'b0, dqval}, 32'd1);
      chk("data_burst", DATAOUT, exp_word(k0 + k));
      chk("rdy_burst", {31'b0, wrbstrdy}, 32'd0);
      if (k == abort_k) begin
        reset = 1'b1;
        #1;
        chk("rst_dqval", {31'b0, dqval}, 32'd0);
        chk("rst_rdy", {31'b0, wrbstrdy}, 32'd0);
        chk("rst_ovf", {31'b0, ovf}, 32'd0);
        chk("rst_unf", {31'b0, unf}, 32'd0);
        chk("rst_data", DATAOUT, 32'd0);
        return;
      end
    end
    @(negedge clk);
    chk("dqval_after", {31'b0, dqval}, 32'd0);
    chk("bstdone_early", {31'b0, bstdone}, 32'd0);
    @(negedge clk);
    chk("bstdone_pulse", {31'b0, bstdone}, 32'd1);
    @(negedge clk);
    chk("bstdone_late", {31'b0, bstdone}, 32'd0);
    chk("dqval_idle", {31'b0, dqval}, 32'd0);
    // let the level flag settle after the reads before looking at wrbstrdy
    repeat (10) @(negedge clk);
  endtask

  initial begin
    bit seen;
    int idx;
    reset    = 1'b1;
    wrbstack = 1'b0;
    exp_tri  = 16'hA5A5;
    exp_st   = 16'h5A5A;
    split    = 0;
    b0       = 0;
    b1       = 0;

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_rdy", {31'b0, wrbstrdy}, 32'd0);
    chk("reset_dqval", {31'b0, dqval}, 32'd0);
    chk("reset_bstdone", {31'b0, bstdone}, 32'd0);
    chk("reset_ovf", {31'b0, ovf}, 32'd0);
    chk("reset_unf", {31'b0, unf}, 32'd0);
    chk("reset_data", DATAOUT, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // enable for 6 capclks: drops during slot 2 of frame 1, so 8 words total
    en_cycles = 6;
    repeat (20) @(negedge clk);
    chk("part_rdy", {31'b0, wrbstrdy}, 32'd0);
    chk("part_ovf", {31'b0, ovf}, 32'd0);
    b0    = start_log[0];
    split = 8;

    // continuous capture, first burst
    en_cycles = -1;
    repeat (2) @(negedge clk);
    b1 = start_log[1];
    run_burst(0, -1);
    chk("unf_after_b1", {31'b0, unf}, 32'd0);

    // no more bursts: fill until a frame is refused
    seen = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (ovf === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("ovf_set", {31'b0, seen}, 32'd1);
    en_cycles = 0;
    repeat (20) @(negedge clk);
    chk("ovf_sticky", {31'b0, ovf}, 32'd1);

    // FIFO holds exactly 1020 words: three bursts, then 252 left (not offered)
    run_burst(256, -1);
    run_burst(512, -1);
    run_burst(768, -1);
    repeat (20) @(negedge clk);
    chk("drain_rest_rdy", {31'b0, wrbstrdy}, 32'd0);
    chk("drain_unf", {31'b0, unf}, 32'd0);
    chk("drain_ovf", {31'b0, ovf}, 32'd1);

    // reset in the middle of a burst (leftover words first, reset at k=100)
    en_cycles = -1;
    run_burst(1024, 100);
    en_cycles = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("post_rst_rdy", {31'b0, wrbstrdy}, 32'd0);
    chk("post_rst_ovf", {31'b0, ovf}, 32'd0);
    chk("post_rst_dqval", {31'b0, dqval}, 32'd0);

    // fresh capture with new tri-state data; sequence restarts at 0
    tri_v   = 16'h00FF;
    st_v    = 16'h0F0F;
    exp_tri = 16'h00FF;
    exp_st  = 16'h0F0F;
    idx     = start_log.size();
    en_cycles = -1;
    repeat (2) @(negedge clk);
    split = 0;
    b1    = start_log[idx];
    run_burst(0, -1);
    chk("final_unf", {31'b0, unf}, 32'd0);
    en_cycles = 0;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
